// File: rtl/ring_decoder.sv
// Receive-side decoder for the 4-bit one-hot rotating LED ring.
// It synchronizes and debounces the pattern, then tracks position, direction and a wrapping step count.
module ring_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         leds,
  output logic [1:0]         pos,
  output logic               dir,
  output logic               step,
  output logic [COUNT_W-1:0] count,
  output logic               locked,
  output logic               err_skip,
  output logic               err_illegal
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  function automatic logic is_onehot(input logic [3:0] p);
    return (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (p[i]) idx = 2'(i);
    return idx;
  endfunction

  logic [3:0] sync_p0, sync_p1;
  logic [3:0] cand_p2;
  logic [7:0] stab_p2;
  logic       acc_p2;
  logic       vld_p3;
  logic [3:0] pat_p3;

  state_t             state, state_n;
  logic [1:0]         pos_n;
  logic               dir_n, step_n, skip_n, ill_n;
  logic [COUNT_W-1:0] count_n;
  logic [1:0]         new_idx, delta;

  // Acceptance fires only on the edge where stab reaches STAB_MAX; a reload counts as reaching 1.
  always_comb begin
    if (sync_p1 != cand_p2) acc_p2 = (STAB_MAX == 8'd1);
    else                    acc_p2 = (stab_p2 == STAB_MAX - 8'd1);
  end

  // p0/p1: two-flop synchronizer; p2: stability filter; p3: accepted pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 4'b0000;
      sync_p1 <= 4'b0000;
      cand_p2 <= 4'b0000;
      stab_p2 <= 8'd0;
      vld_p3  <= 1'b0;
      pat_p3  <= 4'b0000;
    end else begin
      sync_p0 <= leds;
      sync_p1 <= sync_p0;
      vld_p3  <= acc_p2;
      pat_p3  <= sync_p1;
      if (sync_p1 != cand_p2) begin
        cand_p2 <= sync_p1;
        stab_p2 <= 8'd1;
      end else if (stab_p2 != STAB_MAX) begin
        stab_p2 <= stab_p2 + 8'd1;
      end
    end
  end

  assign new_idx = onehot_idx(pat_p3);
  assign delta   = new_idx - pos;

  always_comb begin
    state_n = state;
    pos_n   = pos;
    dir_n   = dir;
    count_n = count;
    step_n  = 1'b0;
    skip_n  = 1'b0;
    ill_n   = 1'b0;
    if (vld_p3) begin
      if (!is_onehot(pat_p3)) begin
        ill_n   = 1'b1;
        state_n = UNLOCKED;
      end else if (state == UNLOCKED) begin
        pos_n   = new_idx;
        state_n = LOCKED;
      end else begin
        case (delta)
          2'd1: begin
            step_n  = 1'b1;
            dir_n   = 1'b1;
            count_n = count + COUNT_W'(1);
            pos_n   = new_idx;
          end
          2'd3: begin
            step_n  = 1'b1;
            dir_n   = 1'b0;
            count_n = count - COUNT_W'(1);
            pos_n   = new_idx;
          end
          2'd2: begin
            skip_n = 1'b1;
            pos_n  = new_idx;
          end
          default: ;
        endcase
      end
    end
  end

  // p4: decoded outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= UNLOCKED;
      pos         <= 2'd0;
      dir         <= 1'b1;
      count       <= '0;
      step        <= 1'b0;
      err_skip    <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state       <= state_n;
      pos         <= pos_n;
      dir         <= dir_n;
      count       <= count_n;
      step        <= step_n;
      err_skip    <= skip_n;
      err_illegal <= ill_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule
